div_sequencer: RTL



---
 rtl/div_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M DIV/DIVU/REM/REMU controller.
// It runs a radix-2 restoring shift/subtract loop for XLEN iterations.
// Operands are converted to magnitudes on entry and the signs are fixed up
// in a single FIX cycle. Divide-by-zero and signed overflow skip the loop.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [1:0]      DIV_OP,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;          // op[0]=unsigned, op[1]=remainder
  logic [XLEN-1:0] dvd_q, dvd_d;        // dividend shifting out, quotient shifting in
  logic [XLEN-1:0] dvs_q, dvs_d;        // divisor magnitude
  logic [XLEN:0]   rem_q, rem_d;        // partial remainder
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qsign_q, qsign_d;
  logic            rsign_q, rsign_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [XLEN:0]   rem_shift, rem_sub;
  logic            rem_ge;
  logic            signed_op, neg1, neg2;
  logic [XLEN-1:0] abs1, abs2, q_fix, r_fix;

  // Next-state, datapath step and registered-output decode
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;

    // Shifting the whole accumulator keeps every bit observed; the top bit
    // is always zero because rem < divisor after each step.
    rem_shift = (rem_q << 1) | {{XLEN{1'b0}}, dvd_q[XLEN-1]};
    rem_sub   = rem_shift - {1'b0, dvs_q};
    rem_ge    = rem_shift >= {1'b0, dvs_q};

    signed_op = ~DIV_OP[0];
    neg1      = signed_op & DATA1[XLEN-1];
    neg2      = signed_op & DATA2[XLEN-1];
    abs1      = neg1 ? (~DATA1 + ONE) : DATA1;
    abs2      = neg2 ? (~DATA2 + ONE) : DATA2;

    q_fix = qsign_q ? (~dvd_q + ONE) : dvd_q;
    r_fix = rsign_q ? (~rem_q[XLEN-1:0] + ONE) : rem_q[XLEN-1:0];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          op_d = DIV_OP;
          if (DATA2 == '0) begin
            result_d = DIV_OP[1] ? DATA1 : '1;
            state_d  = S_DONE;
          end else if (signed_op && DATA1 == SMIN && DATA2 == '1) begin
            result_d = DIV_OP[1] ? '0 : SMIN;
            state_d  = S_DONE;
          end else begin
            dvd_d   = abs1;
            dvs_d   = abs2;
            qsign_d = neg1 ^ neg2;
            rsign_d = neg1;
            rem_d   = '0;
            cnt_d   = CW'(XLEN-1);
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rem_d = rem_ge ? rem_sub : rem_shift;
        dvd_d = {dvd_q[XLEN-2:0], rem_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = op_q[1] ? r_fix : q_fix;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a same-cycle START
    if (FLUSH) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end

    busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule
